// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: CPU-side data-memory request/response bundle
interface dmem_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, err, busy
  );
  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: segment-relative byte/half/word data memory with checked accesses and configurable read latency
module dmem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          RD_LAT      = 1
) (
  input  logic        clk_in,
  input  logic        reset,
  dmem_ctrl_if.slave  bus
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  RD_WAIT = 2'd1;
  localparam logic [1:0]  RESP    = 2'd2;
  logic [1:0]    state;
  logic [2:0]    cnt;
  logic [AW-1:0] c_idx;
  logic [1:0]    c_lane;
  logic [1:0]    c_size;
  logic          c_sext;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          bad;
  logic          wr;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic          r_sext;
  logic [31:0]   rword;
  logic [31:0]   sh;
  logic [31:0]   ld;
  // decode the incoming address and build the write lanes and the extended load word
  always_comb begin
    off    = bus.addr - BASE_ADDR;
    idx    = off[AW+1:2];
    bad    = (off >= SPAN) || (bus.size == 2'b11) ||
             (bus.size == 2'b01 && off[0]) || (bus.size == 2'b10 && off[1:0] != 2'b00);
    wr     = reset && state == IDLE && bus.req && bus.we && !bad;
    be     = bus.size == 2'b00 ? 4'b0001 << off[1:0] :
             bus.size == 2'b01 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wd     = bus.size == 2'b00 ? {4{bus.wdata[7:0]}} :
             bus.size == 2'b01 ? {2{bus.wdata[15:0]}} : bus.wdata;
    r_idx  = state == IDLE ? idx : c_idx;
    r_lane = state == IDLE ? off[1:0] : c_lane;
    r_size = state == IDLE ? bus.size : c_size;
    r_sext = state == IDLE ? bus.sign_ext : c_sext;
    rword  = mem[r_idx];
    sh     = rword >> {r_lane, 3'b000};
    ld     = r_size == 2'b00 ? {{24{r_sext & sh[7]}}, sh[7:0]} :
             r_size == 2'b01 ? {{16{r_sext & sh[15]}}, sh[15:0]} : rword;
  end
  // byte-lane store into the word array; storage is never reset
  always_ff @(posedge clk_in)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
  // access sequencing: accept in IDLE, count read latency, pulse ready for one cycle
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bus.rdata <= '0;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
      c_idx     <= '0;
      c_lane    <= '0;
      c_size    <= '0;
      c_sext    <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.req) begin
        c_idx  <= idx;
        c_lane <= off[1:0];
        c_size <= bus.size;
        c_sext <= bus.sign_ext;
        if (bad || bus.we || RD_LAT == 1) begin
          state     <= RESP;
          bus.ready <= 1'b1;
          bus.err   <= bad;
          if (!bad && !bus.we) bus.rdata <= ld;
        end else begin
          state <= RD_WAIT;
          cnt   <= 3'(RD_LAT - 1);
        end
      end
    end else if (state == RD_WAIT) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) begin
        state     <= RESP;
        bus.ready <= 1'b1;
        bus.rdata <= ld;
      end
    end else begin
      state     <= IDLE;
      bus.ready <= 1'b0;
      bus.err   <= 1'b0;
    end
  assign bus.busy = state != IDLE;
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller that replaces the bare word-addressed data RAM instantiation at the CPU top level. It translates full 32-bit CPU data addresses into local offsets using a configurable segment base. It supports byte, halfword and word accesses, with sign/zero extension and byte-lane writes. Reads have configurable latency behind a req/ready handshake, and out-of-range or misaligned accesses are reported instead of silently aliasing.

Parameters:
BASE_ADDR, 32'h10010000, byte address of local offset 0 (data-segment base)
DEPTH_WORDS, 2048, number of 32-bit words stored; power of two, 16..65536
RD_LAT, 1, read latency in cycles from acceptance to ready; legal 1..4

Ports:
clk_in  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  access request, sampled only in IDLE
we  input  1  1 = store, 0 = load; sampled with req
size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
sign_ext  input  1  loads only: 1 = sign-extend, 0 = zero-extend
addr  input  32  CPU byte address
wdata  input  32  store data; byte/half taken from low bits
rdata  output  32  load result, registered
ready  output  1  one-cycle completion pulse
err  output  1  qualifies ready: access rejected
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE, rdata=0, ready=0, err=0, busy=0, latency counter=0. Memory contents are not cleared. Reset mid-access abandons the access; a store not yet committed is not written.
- Offset: off = addr - BASE_ADDR, computed mod 2^32. Word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
- Range error: off >= 4*DEPTH_WORDS. Addresses below BASE wrap to large offsets and are therefore also errors.
- Alignment error: half with off[0]=1; word with off[1:0]!=0.
- size=11 is an error.
- Error precedence is irrelevant because there is a single err flag.
- Byte lanes are little-endian. A byte store writes lane off[1:0] with wdata[7:0]. A half store writes lanes {off[1],0}+1:0 with wdata[15:0]. A word store writes all lanes. Other lanes are preserved.
- Loads select the same lanes and extend to 32 bits according to sign_ext. sign_ext is ignored for word loads.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE: busy=0. On an edge with req=1, capture we/size/sign_ext/off/wdata; call this edge E0.
  - Error: go to RESP with err=1 and ready=1 after E0. No memory change; rdata unchanged.
  - Store: memory written at E0; next state RESP with ready=1, err=0 after E0.
  - Load with RD_LAT=1: memory read at E0; rdata and ready=1 valid after E0.
  - Load with RD_LAT>1: go to RD_WAIT, counter=RD_LAT-1.
- RD_WAIT: decrement counter each edge. At the edge where the counter reaches 0, register rdata and set ready=1, entering RESP. ready is therefore first high in the cycle after edge E(RD_LAT-1+1), i.e. RD_LAT cycles after E0 counted inclusively: load ready after E0+RD_LAT-1 edges.
- RESP: ready (and err if applicable) high for exactly one cycle. Next edge returns to IDLE and clears ready/err.
  - req during RESP is ignored.
  - req held high is accepted at the first IDLE edge.
  - Maximum rate: one access per 2 cycles for stores and errors, RD_LAT+1 cycles for loads.
- busy=1 in RD_WAIT and RESP. Inputs other than clk_in and reset are don't-care while busy.
- rdata holds its last load value across stores, errors and idle cycles.
- Storage: inferred synchronous RAM, DEPTH_WORDS x 32, with 4 byte-write enables.

Test Plan:
1. Reset then word store of 0xDEADBEEF to 0x10010000, word load from the same address -> ready pulses once per access, rdata=0xDEADBEEF, err=0.
2. Byte store of 0x80 to 0x10010003, then lb and lbu from 0x10010003 -> rdata=0xFFFFFF80 then 0x00000080. Word load of 0x10010000 -> 0x80ADBEEF.
3. Half store of 0x1234 to 0x10010002, half load with sign_ext=1 from 0x10010002 -> 0x00001234. Word load from 0x10010001 -> err=1 with ready, rdata unchanged.
4. Word load from 0x1000FFFC and from BASE+4*DEPTH_WORDS -> err=1. Follow with a word load of 0x10010000 confirming no write occurred.
5. RD_LAT=3: load accepted at edge E0 -> ready high exactly one cycle, after edge E0+2. busy=1 from E0 until ready drops. req held high continuously -> next acceptance one edge after ready.
6. Assert reset low during RD_WAIT -> outputs 0 immediately. A store issued the cycle reset falls is not committed, checked by a later readback.
